// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Capture stage behind the 16-bit ALU.
// Buffers result words and their flags in a small FIFO.
// Also keeps sticky carry/overflow flags and a saturating count of dropped pushes.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake (in_ready = !full)
//   in_z, in_flags       result word and flags {S,ZR,CY,P,V}
//   out_valid/out_ready  consumer handshake (out_valid = !empty)
//   out_z, out_flags     head entry, forced to 0 while empty
//   count                occupancy 0..DEPTH
//   sticky_clr           synchronous clear of sticky_cy, sticky_v, drop_cnt
//   sticky_cy, sticky_v  set by any accepted entry with CY / V
//   drop_cnt             saturating count of cycles with in_valid & !in_ready
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [4:0]       out_flags,
    output logic [CW-1:0]    count,
    input  logic             sticky_clr,
    output logic             sticky_cy,
    output logic             sticky_v,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [WIDTH+4:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_sticky_cy;
    logic               r_sticky_v;
    logic [7:0]         r_drop_cnt;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [WIDTH+4:0]   w_head;

    // Reset asserts immediately but releases on a clock edge, so the FIFO
    // state never leaves reset in the middle of a clock period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = in_valid & ~in_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_z     = out_valid ? w_head[WIDTH+4:5] : '0;
    assign out_flags = out_valid ? w_head[4:0]       : '0;

    assign count     = r_count;
    assign sticky_cy = r_sticky_cy;
    assign sticky_v  = r_sticky_v;
    assign drop_cnt  = r_drop_cnt;

    // Storage holds no reset; stale words are hidden by count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_z, in_flags};
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A setting push outranks a clear; a clear outranks a drop increment.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sticky_cy <= 1'b0;
            r_sticky_v  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_sticky_cy <= (r_sticky_cy & ~sticky_clr) | (w_push & in_flags[2]);
            r_sticky_v  <= (r_sticky_v  & ~sticky_clr) | (w_push & in_flags[0]);
            if (sticky_clr)
                r_drop_cnt <= '0;
            else if (w_drop && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_z;
    logic [4:0]       in_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic [4:0]       out_flags;
    logic [CW-1:0]    count;
    logic             sticky_clr;
    logic             sticky_cy;
    logic             sticky_v;
    logic [7:0]       drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of {z, flags} plus plain sticky/drop values.
    logic [WIDTH+4:0] m_q[$];
    logic             m_cy;
    logic             m_v;
    int               m_drop;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .count      (count),
        .sticky_clr (sticky_clr),
        .sticky_cy  (sticky_cy),
        .sticky_v   (sticky_v),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_z();
        logic [WIDTH+4:0] e;
        if (m_q.size() == 0) return '0;
        e = m_q[0];
        return e[WIDTH+4:5];
    endfunction

    function automatic logic [4:0] exp_f();
        logic [WIDTH+4:0] e;
        if (m_q.size() == 0) return '0;
        e = m_q[0];
        return e[4:0];
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_cy   = 1'b0;
        m_v    = 1'b0;
        m_drop = 0;
    endfunction

    // Apply one cycle of stimulus, advance the model by one edge, and return
    // 1 ns after the edge so outputs are sampled away from it.
    task automatic tick(input logic iv, input logic [WIDTH-1:0] z, input logic [4:0] f,
                        input logic ordy, input logic clr);
        bit push, pop, full;
        in_valid   = iv;
        in_z       = z;
        in_flags   = f;
        out_ready  = ordy;
        sticky_clr = clr;
        full = (m_q.size() == DEPTH);
        push = iv && !full;
        pop  = ordy && (m_q.size() != 0);
        @(posedge clk);
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({z, f});
        m_cy = (m_cy && !clr) || (push && f[2]);
        m_v  = (m_v  && !clr) || (push && f[0]);
        if (clr) m_drop = 0;
        else if (iv && full && m_drop < 255) m_drop++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        in_valid = 0; in_z = '0; in_flags = '0; out_ready = 0; sticky_clr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (count !== 3'd0)     begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_vec++; if (out_z !== 16'h0000 || out_flags !== 5'b0)
            begin n_err++; $display("FAIL rst_out_data got %h/%b want 0000/00000", out_z, out_flags); end
        n_vec++; if (sticky_cy !== 1'b0 || sticky_v !== 1'b0 || drop_cnt !== 8'd0)
            begin n_err++; $display("FAIL rst_sticky got cy=%b v=%b drop=%0d want 0 0 0", sticky_cy, sticky_v, drop_cnt); end
        for (int i = 0; i < 3; i++) tick(1'b1, 16'(i + 16'h0100), 5'b00101, 1'b0, 1'b0);
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count got %0d want 3", count); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL rst_async got count=%0d ov=%b want 0 0", count, out_valid); end
        n_vec++; if (sticky_cy !== 1'b0 || sticky_v !== 1'b0)
            begin n_err++; $display("FAIL rst_async_sticky got cy=%b v=%b want 0 0", sticky_cy, sticky_v); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_single();
        tick(1'b1, 16'h0fff, 5'b00101, 1'b0, 1'b0);
        n_vec++; if (out_valid !== 1'b1 || count !== 3'd1)
            begin n_err++; $display("FAIL single_valid got ov=%b count=%0d want 1 1", out_valid, count); end
        n_vec++; if (out_z !== 16'h0fff || out_flags !== 5'b00101)
            begin n_err++; $display("FAIL single_data got %h/%b want 0fff/00101", out_z, out_flags); end
        n_vec++; if (sticky_cy !== 1'b1 || sticky_v !== 1'b1)
            begin n_err++; $display("FAIL single_sticky got cy=%b v=%b want 1 1", sticky_cy, sticky_v); end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0)
            begin n_err++; $display("FAIL single_pop got ov=%b count=%0d want 0 0", out_valid, count); end
        n_vec++; if (out_z !== 16'h0 || out_flags !== 5'b0)
            begin n_err++; $display("FAIL single_empty_data got %h/%b want 0/0", out_z, out_flags); end
    endtask

    task automatic test_fill();
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) tick(1'b1, 16'(i), 5'b10010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 16'h0005, 5'b00101, 1'b0, 1'b0);
        n_vec++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin n_err++; $display("FAIL fill_full got count=%0d ir=%b want 4 0", count, in_ready); end
        n_vec++; if (drop_cnt !== 8'd3) begin n_err++; $display("FAIL fill_drop got %0d want 3", drop_cnt); end
        n_vec++; if (sticky_cy !== 1'b0 || sticky_v !== 1'b0)
            begin n_err++; $display("FAIL fill_sticky got cy=%b v=%b want 0 0", sticky_cy, sticky_v); end
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (out_valid !== 1'b1 || out_z !== 16'(i) || out_flags !== 5'b10010)
                begin n_err++; $display("FAIL fill_drain%0d got ov=%b %h/%b want 1 %h/10010", i, out_valid, out_z, out_flags, 16'(i)); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0)
            begin n_err++; $display("FAIL fill_after got ov=%b count=%0d want 0 0", out_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] base;
        base = 16'($urandom);
        tick(1'b1, base, 5'b01000, 1'b0, 1'b0);
        tick(1'b1, base + 16'd1, 5'b01000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (out_z !== base + 16'(i))
                begin n_err++; $display("FAIL b2b_order%0d got %h want %h", i, out_z, base + 16'(i)); end
            tick(1'b1, base + 16'(i + 2), 5'($urandom), 1'b1, 1'b0);
            n_vec++; if (count !== 3'd2 || out_z !== exp_z() || out_flags !== exp_f())
                begin n_err++; $display("FAIL b2b%0d got count=%0d %h/%b want 2 %h/%b", i, count, out_z, out_flags, exp_z(), exp_f()); end
        end
        idle(0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) tick(1'b1, 16'($urandom), 5'($urandom), 1'b0, 1'b0);
        tick(1'b1, 16'hAAAA, 5'b11111, 1'b1, 1'b0);
        n_vec++; if (count !== 3'd3 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL fullpop_cnt got count=%0d ir=%b want 3 1", count, in_ready); end
        tick(1'b1, 16'hBBBB, 5'b00000, 1'b0, 1'b0);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fullpop_push got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_z !== exp_z() || out_flags !== exp_f())
                begin n_err++; $display("FAIL fullpop_drain%0d got %h/%b want %h/%b", i, out_z, out_flags, exp_z(), exp_f()); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got %b want 0", out_valid); end
    endtask

    task automatic test_sticky();
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 16'(i), 5'b00001, 1'b0, 1'b0);
        tick(1'b1, 16'h0, 5'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0, 5'b0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        n_vec++; if (drop_cnt !== 8'd2 || sticky_v !== 1'b1 || sticky_cy !== 1'b0)
            begin n_err++; $display("FAIL sticky_pre got drop=%0d v=%b cy=%b want 2 1 0", drop_cnt, sticky_v, sticky_cy); end
        tick(1'b1, 16'h1234, 5'b00100, 1'b0, 1'b1);
        n_vec++; if (sticky_cy !== 1'b1 || sticky_v !== 1'b0 || drop_cnt !== 8'd0)
            begin n_err++; $display("FAIL sticky_clr got cy=%b v=%b drop=%0d want 1 0 0", sticky_cy, sticky_v, drop_cnt); end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 16'h5555, 5'b00101, 1'b0, 1'b0);
            if (i == 254 || i == 299) begin
                n_vec++; if (drop_cnt !== 8'(m_drop))
                    begin n_err++; $display("FAIL sticky_sat%0d got %0d want %0d", i, drop_cnt, m_drop); end
            end
        end
        n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sticky_sat got %0d want 255", drop_cnt); end
        for (int i = 0; i < 4; i++) tick(1'b0, '0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            n_vec++;
            if (count !== CW'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
                in_ready !== (m_q.size() != DEPTH) || out_z !== exp_z() || out_flags !== exp_f() ||
                sticky_cy !== m_cy || sticky_v !== m_v || drop_cnt !== 8'(m_drop)) begin
                n_err++;
                $display("FAIL rand%0d got cnt=%0d %h/%b cy=%b v=%b drop=%0d want cnt=%0d %h/%b cy=%b v=%b drop=%0d",
                         i, count, out_z, out_flags, sticky_cy, sticky_v, drop_cnt,
                         m_q.size(), exp_z(), exp_f(), m_cy, m_v, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_full_pop();
        test_sticky();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
